vid_pattern_gen: RTL and testbench

//  Parametrised successor of the 4-register vid_gen AXI4-Lite peripheral.
//  - Adds a frame-based video test-pattern source. An AXI4-Lite slave register bank sets

---
 rtl/vid_pattern_gen.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_vid_pattern_gen.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vid_pattern_gen.sv
// Video test-pattern source: AXI4-Lite register bank driving an AXI4-Stream video master.
// Frame geometry, mode and colour are shadowed at each frame start so mid-frame writes take effect next frame.
module vid_pattern_gen #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
    parameter int unsigned PIX_WIDTH          = 24,
    parameter int unsigned CNT_WIDTH          = 12
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [PIX_WIDTH-1:0]            m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tuser,
    output logic                            m_axis_tlast,
    output logic                            frame_done
);

    localparam int unsigned IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
    localparam int unsigned LANES  = PIX_WIDTH / 8;
    localparam int unsigned FCNT_W = 32;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Register bank
    logic                  ctrl_en_q;
    logic [1:0]            ctrl_mode_q;
    logic [CNT_WIDTH-1:0]  hsize_q;
    logic [CNT_WIDTH-1:0]  vsize_q;
    logic [PIX_WIDTH-1:0]  color_q;
    logic [FCNT_W-1:0]     fcnt_q;
    logic [FCNT_W-1:0]     fcnt_d;

    // AXI4-Lite handshake state
    logic                          awready_q;
    logic                          bvalid_q;
    logic                          arready_q;
    logic                          rvalid_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_mux_c;
    logic                          wr_en_c;
    logic                          rd_en_c;
    logic [IDX_W-1:0]              wr_idx_c;
    logic [IDX_W-1:0]              rd_idx_c;

    // Frame generator state
    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  x_q, x_d;
    logic [CNT_WIDTH-1:0]  y_q, y_d;
    logic [CNT_WIDTH-1:0]  hlast_q, hlast_d;
    logic [CNT_WIDTH-1:0]  vlast_q, vlast_d;
    logic [1:0]            mode_q, mode_d;
    logic [PIX_WIDTH-1:0]  scolor_q, scolor_d;
    logic                  tvalid_q, tvalid_d;
    logic [PIX_WIDTH-1:0]  tdata_q, tdata_d;
    logic                  tuser_q, tuser_d;
    logic                  tlast_q, tlast_d;
    logic                  start_c;
    logic                  beat_c;
    logic                  frame_end_c;
    logic [CNT_WIDTH-1:0]  cfg_hlast_c;
    logic [CNT_WIDTH-1:0]  cfg_vlast_c;

    logic unused_ok;
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_wdata,
                         s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // One pixel for the given coordinates; every 8-bit lane is filled for ramp/counter modes
    function automatic logic [PIX_WIDTH-1:0] pixel(
        input logic [1:0]           mode,
        input logic [PIX_WIDTH-1:0] color,
        input logic [7:0]           xb,
        input logic                 ysel,
        input logic [7:0]           fc
    );
        logic [PIX_WIDTH-1:0] p;
        p = color;
        case (mode)
            2'd0: p = color;
            2'd1: for (int unsigned i = 0; i < LANES; i++) p[i*8 +: 8] = xb;
            2'd2: p = (xb[4] ^ ysel) ? ~color : color;
            default: for (int unsigned i = 0; i < LANES; i++) p[i*8 +: 8] = fc;
        endcase
        return p;
    endfunction

    assign wr_idx_c = s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_idx_c = s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_en_c  = awready_q & s_axi_awvalid & s_axi_wvalid;
    assign rd_en_c  = arready_q & s_axi_arvalid;

    // Write channel and byte-strobed register updates
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            awready_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            ctrl_en_q   <= 1'b0;
            ctrl_mode_q <= 2'd0;
            hsize_q     <= '0;
            vsize_q     <= '0;
            color_q     <= '0;
        end else begin
            awready_q <= ~awready_q & s_axi_awvalid & s_axi_wvalid & ~bvalid_q;
            if (wr_en_c) begin
                bvalid_q <= 1'b1;
                if (wr_idx_c == IDX_W'(0)) begin
                    if (s_axi_wstrb[0]) begin
                        ctrl_en_q   <= s_axi_wdata[0];
                        ctrl_mode_q <= s_axi_wdata[2:1];
                    end
                end else if (wr_idx_c == IDX_W'(1)) begin
                    for (int unsigned b = 0; b < CNT_WIDTH; b++)
                        if (s_axi_wstrb[b/8]) hsize_q[b] <= s_axi_wdata[b];
                end else if (wr_idx_c == IDX_W'(2)) begin
                    for (int unsigned b = 0; b < CNT_WIDTH; b++)
                        if (s_axi_wstrb[b/8]) vsize_q[b] <= s_axi_wdata[b];
                end else if (wr_idx_c == IDX_W'(3)) begin
                    for (int unsigned b = 0; b < PIX_WIDTH; b++)
                        if (s_axi_wstrb[b/8]) color_q[b] <= s_axi_wdata[b];
                end
            end else if (bvalid_q && s_axi_bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Read mux; FCNT is sampled before any same-edge increment
    always_comb begin
        rd_mux_c = '0;
        if (rd_idx_c == IDX_W'(0))
            rd_mux_c = C_S_AXI_DATA_WIDTH'({ctrl_mode_q, ctrl_en_q});
        else if (rd_idx_c == IDX_W'(1))
            rd_mux_c = C_S_AXI_DATA_WIDTH'(hsize_q);
        else if (rd_idx_c == IDX_W'(2))
            rd_mux_c = C_S_AXI_DATA_WIDTH'(vsize_q);
        else if (rd_idx_c == IDX_W'(3))
            rd_mux_c = C_S_AXI_DATA_WIDTH'(color_q);
        else if (rd_idx_c == IDX_W'(4))
            rd_mux_c = C_S_AXI_DATA_WIDTH'(fcnt_q);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            arready_q <= ~arready_q & s_axi_arvalid & ~rvalid_q;
            if (rd_en_c) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux_c;
            end else if (rvalid_q && s_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = awready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;

    // A size of 0 behaves as 1
    assign cfg_hlast_c = (hsize_q == '0) ? '0 : hsize_q - CNT_WIDTH'(1);
    assign cfg_vlast_c = (vsize_q == '0) ? '0 : vsize_q - CNT_WIDTH'(1);

    assign beat_c      = tvalid_q & m_axis_tready;
    assign frame_end_c = beat_c & tlast_q & (y_q == vlast_q);
    assign fcnt_d      = fcnt_q + FCNT_W'(frame_end_c);

    // Next-state logic; stream outputs are computed one beat ahead so they leave flops
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        hlast_d  = hlast_q;
        vlast_d  = vlast_q;
        mode_d   = mode_q;
        scolor_d = scolor_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tuser_d  = tuser_q;
        tlast_d  = tlast_q;
        start_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_en_q) begin
                    state_d = ST_RUN;
                    start_c = 1'b1;
                end
            end
            ST_RUN: begin
                if (frame_end_c) begin
                    if (ctrl_en_q) begin
                        start_c = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        x_d      = '0;
                        y_d      = '0;
                        tvalid_d = 1'b0;
                        tdata_d  = '0;
                        tuser_d  = 1'b0;
                        tlast_d  = 1'b0;
                    end
                end else if (beat_c) begin
                    if (x_q == hlast_q) begin
                        x_d = '0;
                        y_d = y_q + CNT_WIDTH'(1);
                    end else begin
                        x_d = x_q + CNT_WIDTH'(1);
                    end
                    tdata_d = pixel(mode_q, scolor_q, 8'(x_d), y_d[4], fcnt_q[7:0]);
                    tuser_d = 1'b0;
                    tlast_d = (x_d == hlast_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Frame start: shadow the live configuration and present pixel (0,0)
        if (start_c) begin
            x_d      = '0;
            y_d      = '0;
            hlast_d  = cfg_hlast_c;
            vlast_d  = cfg_vlast_c;
            mode_d   = ctrl_mode_q;
            scolor_d = color_q;
            tvalid_d = 1'b1;
            tuser_d  = 1'b1;
            tlast_d  = (cfg_hlast_c == '0);
            tdata_d  = pixel(ctrl_mode_q, color_q, 8'd0, 1'b0, fcnt_d[7:0]);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            hlast_q  <= '0;
            vlast_q  <= '0;
            mode_q   <= 2'd0;
            scolor_q <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            hlast_q  <= hlast_d;
            vlast_q  <= vlast_d;
            mode_q   <= mode_d;
            scolor_q <= scolor_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tlast  = tlast_q;
    assign frame_done    = frame_end_c;

endmodule

// File: tb/tb_vid_pattern_gen.sv
// Bench for vid_pattern_gen: register table plus scoreboarded video frames,
// backpressure, disable/config change mid-frame and asynchronous reset mid-frame.
module tb_vid_pattern_gen;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [4:0]  s_axi_awaddr = '0;
    logic [2:0]  s_axi_awprot = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [4:0]  s_axi_araddr = '0;
    logic [2:0]  s_axi_arprot = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tuser;
    logic        m_axis_tlast;
    logic        frame_done;

    vid_pattern_gen dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tuser(m_axis_tuser),
        .m_axis_tlast(m_axis_tlast), .frame_done(frame_done)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [23:0] data;
        logic        user;
        logic        last;
        logic        fd;
    } beat_t;

    typedef struct {
        logic [4:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rd;
    } reg_vec_t;

    int    errors = 0;
    int    checks = 0;
    int    beats  = 0;
    beat_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] model_pix(int mode, logic [23:0] color, int x, int y, int f);
        logic [7:0] xb;
        logic [7:0] fb;
        xb = 8'(x);
        fb = 8'(f);
        case (mode)
            0: return color;
            1: return {xb, xb, xb};
            2: return ((((x >> 4) ^ (y >> 4)) & 1) != 0) ? ~color : color;
            default: return {fb, fb, fb};
        endcase
    endfunction

    task automatic push_frame(int hs, int vs, int mode, logic [23:0] color, int f);
        beat_t b;
        for (int y = 0; y < vs; y++)
            for (int x = 0; x < hs; x++) begin
                b.data = model_pix(mode, color, x, y, f);
                b.user = (x == 0 && y == 0);
                b.last = (x == hs - 1);
                b.fd   = (x == hs - 1 && y == vs - 1);
                sb.push_back(b);
            end
    endtask

    // Stream monitor: pops the scoreboard on every accepted beat and checks stall stability
    logic        stall_prev = 1'b0;
    logic [26:0] stall_vals = '0;
    always @(negedge ACLK) begin
        beat_t e;
        if (!ARESETN) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && m_axis_tvalid)
                check("stall_hold", 32'({m_axis_tdata, m_axis_tuser, m_axis_tlast}), 32'(stall_vals));
            if (m_axis_tvalid && m_axis_tready) begin
                beats++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %h with no expected beat", m_axis_tdata);
                end else begin
                    e = sb.pop_front();
                    check("beat", 32'({m_axis_tdata, m_axis_tuser, m_axis_tlast, frame_done}),
                          32'({e.data, e.user, e.last, e.fd}));
                end
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            stall_vals = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
        end
    end

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        bit ok;
        @(posedge ACLK); #1;
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge ACLK);
            if (s_axi_awready && s_axi_wready) begin ok = 1; break; end
        end
        if (!ok) check("aw_timeout", 32'(0), 32'(1));
        @(posedge ACLK); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            if (s_axi_bvalid) begin ok = 1; break; end
            @(negedge ACLK);
        end
        if (!ok) check("b_timeout", 32'(0), 32'(1));
        check("bresp", 32'(s_axi_bresp), 32'(0));
        s_axi_bready = 1'b1;
        @(posedge ACLK); #1;
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
        bit ok;
        @(posedge ACLK); #1;
        s_axi_araddr = a; s_axi_arvalid = 1'b1;
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge ACLK);
            if (s_axi_arready) begin ok = 1; break; end
        end
        if (!ok) check("ar_timeout", 32'(0), 32'(1));
        @(posedge ACLK); #1;
        s_axi_arvalid = 1'b0;
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            if (s_axi_rvalid) begin ok = 1; break; end
            @(negedge ACLK);
        end
        if (!ok) check("r_timeout", 32'(0), 32'(1));
        d = s_axi_rdata;
        check("rresp", 32'(s_axi_rresp), 32'(0));
        s_axi_rready = 1'b1;
        @(posedge ACLK); #1;
        s_axi_rready = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        for (int n = 0; n < budget && sb.size() != 0; n++) @(negedge ACLK);
        #1;
        check(name, 32'(sb.size()), 32'(0));
        sb.delete();
    endtask

    task automatic wait_beats(input int target, input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge ACLK); #1;
            if (beats >= target) break;
        end
        if (n >= budget) check("beat_wait_timeout", 32'(beats), 32'(target));
    endtask

    task automatic idle_check(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge ACLK);
            if (m_axis_tvalid) seen++;
        end
        check(name, 32'(seen), 32'(0));
    endtask

    reg_vec_t    regs[10];
    logic [31:0] rd;
    int          exp_fcnt;
    int          base;

    initial begin
        regs[0] = '{5'h00, 1'b0, 32'h0,        4'h0, 32'h0};
        regs[1] = '{5'h04, 1'b0, 32'h0,        4'h0, 32'h0};
        regs[2] = '{5'h10, 1'b0, 32'h0,        4'h0, 32'h0};
        regs[3] = '{5'h0C, 1'b1, 32'h00A5A5A5, 4'h1, 32'h000000A5};
        regs[4] = '{5'h18, 1'b0, 32'h0,        4'h0, 32'h0};
        regs[5] = '{5'h04, 1'b1, 32'hFFFFFFFF, 4'h3, 32'h00000FFF};
        regs[6] = '{5'h18, 1'b1, 32'hDEADBEEF, 4'hF, 32'h0};
        regs[7] = '{5'h10, 1'b1, 32'h00001234, 4'hF, 32'h0};
        regs[8] = '{5'h08, 1'b1, 32'h00000002, 4'hF, 32'h00000002};
        regs[9] = '{5'h00, 1'b1, 32'hFFFFFFF6, 4'hF, 32'h00000006};

        #2;
        check("rst_axi", 32'({s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
                              s_axi_arready, s_axi_rresp, s_axi_rvalid}), 32'(0));
        check("rst_rdata", s_axi_rdata, 32'(0));
        check("rst_stream", 32'({m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast, frame_done}), 32'(0));
        repeat (3) @(posedge ACLK);
        #1 ARESETN = 1'b1;

        // T1: register table
        for (int i = 0; i < 10; i++) begin
            if (regs[i].wr) axi_write(regs[i].addr, regs[i].wdata, regs[i].wstrb);
            axi_read(regs[i].addr, rd);
            check($sformatf("reg%0d_%h", i, regs[i].addr), rd, regs[i].exp_rd);
        end
        exp_fcnt = 0;

        // T2: solid frame 4x2; EN cleared while stalled so exactly one frame runs
        m_axis_tready = 1'b0;
        axi_write(5'h0C, 32'h00123456, 4'hF);
        axi_write(5'h04, 32'd4, 4'hF);
        axi_write(5'h08, 32'd2, 4'hF);
        push_frame(4, 2, 0, 24'h123456, exp_fcnt);
        axi_write(5'h00, 32'h1, 4'hF);
        axi_write(5'h00, 32'h0, 4'hF);
        @(posedge ACLK); #1 m_axis_tready = 1'b1;
        drain("t2_drain", 100);
        exp_fcnt++;
        idle_check("t2_idle", 8);
        axi_read(5'h10, rd);
        check("t2_fcnt", rd, 32'(exp_fcnt));

        // T3: horizontal ramp under toggling backpressure
        m_axis_tready = 1'b0;
        axi_write(5'h04, 32'd8, 4'hF);
        axi_write(5'h08, 32'd1, 4'hF);
        push_frame(8, 1, 1, 24'h0, exp_fcnt);
        axi_write(5'h00, 32'h3, 4'hF);
        axi_write(5'h00, 32'h2, 4'hF);
        for (int n = 0; n < 200 && sb.size() != 0; n++) begin
            @(posedge ACLK); #1 m_axis_tready = ~m_axis_tready;
        end
        drain("t3_drain", 4);
        exp_fcnt++;
        m_axis_tready = 1'b1;
        idle_check("t3_idle", 8);
        axi_read(5'h10, rd);
        check("t3_fcnt", rd, 32'(exp_fcnt));

        // T4: checker frame, EN cleared a few beats in; frame still completes
        axi_write(5'h04, 32'd40, 4'hF);
        axi_write(5'h08, 32'd2, 4'hF);
        axi_write(5'h0C, 32'h000F00FF, 4'hF);
        push_frame(40, 2, 2, 24'h0F00FF, exp_fcnt);
        base = beats;
        axi_write(5'h00, 32'h5, 4'hF);
        wait_beats(base + 3, 50);
        axi_write(5'h00, 32'h4, 4'hF);
        drain("t4_drain", 300);
        exp_fcnt++;
        idle_check("t4_idle", 10);
        axi_read(5'h10, rd);
        check("t4_fcnt", rd, 32'(exp_fcnt));

        // T5: HSIZE change mid-frame applies from the next frame; MODE3 shows FCNT
        m_axis_tready = 1'b0;
        axi_write(5'h04, 32'd4, 4'hF);
        axi_write(5'h08, 32'd2, 4'hF);
        push_frame(4, 2, 3, 24'h0, exp_fcnt);
        push_frame(2, 2, 3, 24'h0, exp_fcnt + 1);
        axi_write(5'h00, 32'h7, 4'hF);
        axi_write(5'h04, 32'd2, 4'hF);
        base = beats;
        @(posedge ACLK); #1 m_axis_tready = 1'b1;
        wait_beats(base + 8, 50);
        @(posedge ACLK); #1 m_axis_tready = 1'b0;
        axi_write(5'h00, 32'h6, 4'hF);
        m_axis_tready = 1'b1;
        drain("t5_drain", 100);
        exp_fcnt += 2;
        idle_check("t5_idle", 8);
        axi_read(5'h10, rd);
        check("t5_fcnt", rd, 32'(exp_fcnt));

        // T6: asynchronous reset in the middle of a frame
        axi_write(5'h04, 32'd8, 4'hF);
        axi_write(5'h08, 32'd1, 4'hF);
        axi_write(5'h0C, 32'h00ABCDEF, 4'hF);
        push_frame(8, 1, 0, 24'hABCDEF, exp_fcnt);
        base = beats;
        axi_write(5'h00, 32'h1, 4'hF);
        wait_beats(base + 5, 50);
        ARESETN = 1'b0;
        #1;
        check("t6_rst_stream", 32'({m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast, frame_done}), 32'(0));
        check("t6_rst_axi", 32'({s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
                                 s_axi_arready, s_axi_rresp, s_axi_rvalid}), 32'(0));
        sb.delete();
        repeat (2) @(posedge ACLK);
        #1 ARESETN = 1'b1;
        idle_check("t6_idle", 12);
        axi_read(5'h00, rd);
        check("t6_ctrl", rd, 32'(0));
        axi_read(5'h10, rd);
        check("t6_fcnt", rd, 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
